// File: rtl/delay_pkg.sv
// Shared constants and token/stage types for the delay-unit hierarchy.
package delay_pkg;

    localparam int DATA_WIDTH = 5;
    localparam int DEPTH      = 3;
    localparam int NUM_LANES  = 2;

    typedef logic [DATA_WIDTH-1:0] token_t;

    typedef struct packed {
        logic   valid;
        token_t data;
    } stage_t;

endpackage

// File: rtl/delay_lane.sv
// One elastic lane: DEPTH register stages with a combinational ready chain,
// so bubbles collapse and a full lane still accepts while it drains.
module delay_lane
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = delay_pkg::DATA_WIDTH,
    parameter int DEPTH      = delay_pkg::DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready
);

    stage_t           r_stg [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_up_valid;
    token_t           w_up_data [DEPTH];

    // A stage may advance if it or any stage downstream of it is empty,
    // or the consumer takes the head token this cycle.
    always_comb begin : adv_chain
        logic v_acc;
        w_adv = '0;
        v_acc = i_out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            v_acc    = v_acc | ~r_stg[k].valid;
            w_adv[k] = v_acc;
        end
    end

    always_comb begin
        w_up_valid[0] = i_in_valid;
        w_up_data[0]  = i_in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = r_stg[k-1].valid;
            w_up_data[k]  = r_stg[k-1].data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_stg[k].valid <= w_up_valid[k];
                    // Data is only meaningful alongside a set valid bit.
                    if (w_up_valid[k]) begin
                        r_stg[k].data <= w_up_data[k];
                    end
                end
            end
        end
    end

    assign o_in_ready  = w_adv[0] & i_rst_n;
    assign o_out_valid = r_stg[DEPTH-1].valid;
    assign o_out_data  = r_stg[DEPTH-1].data;

endmodule

// File: rtl/inner_inner_delay_unit.sv
// Two independent fixed-latency elastic delay lanes; lanes never interact.
module inner_inner_delay_unit
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = delay_pkg::DATA_WIDTH,
    parameter int DEPTH      = delay_pkg::DEPTH
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic [DATA_WIDTH-1:0] INPUT_0_data,
    input  logic                  INPUT_0_valid,
    output logic                  INPUT_0_ready,
    input  logic [DATA_WIDTH-1:0] INPUT_1_data,
    input  logic                  INPUT_1_valid,
    output logic                  INPUT_1_ready,
    output logic [DATA_WIDTH-1:0] OUTPUT_0_data,
    output logic                  OUTPUT_0_valid,
    input  logic                  OUTPUT_0_ready,
    output logic [DATA_WIDTH-1:0] OUTPUT_1_data,
    output logic                  OUTPUT_1_valid,
    input  logic                  OUTPUT_1_ready
);

    delay_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane0 (
        .i_clk       (CLK),
        .i_rst_n     (ASYNCRESETN),
        .i_in_data   (INPUT_0_data),
        .i_in_valid  (INPUT_0_valid),
        .o_in_ready  (INPUT_0_ready),
        .o_out_data  (OUTPUT_0_data),
        .o_out_valid (OUTPUT_0_valid),
        .i_out_ready (OUTPUT_0_ready)
    );

    delay_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane1 (
        .i_clk       (CLK),
        .i_rst_n     (ASYNCRESETN),
        .i_in_data   (INPUT_1_data),
        .i_in_valid  (INPUT_1_valid),
        .o_in_ready  (INPUT_1_ready),
        .o_out_data  (OUTPUT_1_data),
        .o_out_valid (OUTPUT_1_valid),
        .i_out_ready (OUTPUT_1_ready)
    );

endmodule

// File: tb/tb_inner_inner_delay_unit.sv
// Bench for inner_inner_delay_unit: scenario tasks plus a queue/age reference model.
module tb_inner_inner_delay_unit;

    localparam int DEPTH = 3;

    logic       CLK;
    logic       rst_n;
    logic [1:0] in_v;
    logic [1:0] out_r;
    logic [4:0] in_d [2];

    logic       o_in_r0, o_in_r1, o_out_v0, o_out_v1;
    logic [4:0] o_out_d0, o_out_d1;
    wire  [1:0] in_r  = {o_in_r1, o_in_r0};
    wire  [1:0] out_v = {o_out_v1, o_out_v0};
    wire  [4:0] out_d [2];
    assign out_d[0] = o_out_d0;
    assign out_d[1] = o_out_d1;

    int n_chk  = 0;
    int n_fail = 0;

    inner_inner_delay_unit dut (
        .CLK            (CLK),
        .ASYNCRESETN    (rst_n),
        .INPUT_0_data   (in_d[0]),
        .INPUT_0_valid  (in_v[0]),
        .INPUT_0_ready  (o_in_r0),
        .INPUT_1_data   (in_d[1]),
        .INPUT_1_valid  (in_v[1]),
        .INPUT_1_ready  (o_in_r1),
        .OUTPUT_0_data  (o_out_d0),
        .OUTPUT_0_valid (o_out_v0),
        .OUTPUT_0_ready (out_r[0]),
        .OUTPUT_1_data  (o_out_d1),
        .OUTPUT_1_valid (o_out_v1),
        .OUTPUT_1_ready (out_r[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each lane is a FIFO of (token, acceptance edge).
    // The oldest token is visible once it has aged DEPTH-1 edges; the lane
    // accepts whenever it holds fewer than DEPTH tokens or the head leaves.
    typedef struct {
        logic [4:0] d;
        int         t;
    } tok_t;

    tok_t q0[$];
    tok_t q1[$];
    int   cyc = 0;

    function automatic int qsize(int l);
        return (l == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic m_valid(int l);
        if (qsize(l) == 0) return 1'b0;
        return ((cyc - ((l == 0) ? q0[0].t : q1[0].t)) >= DEPTH - 1);
    endfunction

    function automatic logic [4:0] m_data(int l);
        if (qsize(l) == 0) return 5'd0;
        return (l == 0) ? q0[0].d : q1[0].d;
    endfunction

    function automatic logic m_ready(int l);
        return rst_n && ((qsize(l) < DEPTH) || out_r[l]);
    endfunction

    initial begin : model
        logic ox [2];
        logic ix [2];
        tok_t nt;
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
            end else begin
                for (int l = 0; l < 2; l++) begin
                    ox[l] = m_valid(l) && out_r[l];
                    ix[l] = in_v[l] && m_ready(l);
                end
                cyc++;
                if (ox[0]) void'(q0.pop_front());
                if (ox[1]) void'(q1.pop_front());
                if (ix[0]) begin nt.d = in_d[0]; nt.t = cyc; q0.push_back(nt); end
                if (ix[1]) begin nt.d = in_d[1]; nt.t = cyc; q1.push_back(nt); end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        in_v  = 2'b00;
        out_r = 2'b11;
        repeat (5) next_cycle();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (out_v[l] !== 1'b0 || out_d[l] !== 5'd0 || in_r[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_init lane%0d got v=%b d=%h r=%b exp 0/00/0", l, out_v[l], out_d[l], in_r[l]);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge CLK);
        n_chk++;
        if (in_r !== 2'b11 || out_v !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b valid=%b exp 11/00", in_r, out_v);
        end
        // Fill both lanes with a stalled consumer, then reset mid-cycle.
        next_cycle();
        out_r = 2'b00;
        in_v  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            in_d[0] = 5'($urandom_range(1, 31));
            in_d[1] = 5'($urandom_range(1, 31));
            next_cycle();
        end
        @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (out_v[l] !== 1'b0 || out_d[l] !== 5'd0 || in_r[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async lane%0d got v=%b d=%h r=%b exp 0/00/0", l, out_v[l], out_d[l], in_r[l]);
            end
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        in_v  = 2'b00;
        out_r = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_chk++;
            if (in_r !== 2'b11 || out_v !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_after k=%0d got ready=%b valid=%b exp 11/00", k, in_r, out_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_latency();
        out_r   = 2'b11;
        in_v    = 2'b01;
        in_d[0] = 5'h15;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            n_chk++;
            if (out_v[0] !== (k == 3) || (k == 3 && out_d[0] !== 5'h15)) begin
                n_fail++;
                $display("FAIL latency k=%0d got v=%b d=%h exp v=%b d=15", k, out_v[0], out_d[0], (k == 3));
            end
            n_chk++;
            if (out_v[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_lane1_idle k=%0d got v=%b exp 0", k, out_v[1]);
            end
            next_cycle();
            in_v[0] = 1'b0;
        end
        drain();
    endtask

    task automatic test_streaming();
        logic exp_v;
        out_r = 2'b11;
        for (int k = 0; k < 38; k++) begin
            in_v[1] = (k < 32);
            in_d[1] = 5'(k);
            @(negedge CLK);
            exp_v = (k >= 3) && (k < 35);
            n_chk++;
            if (out_v[1] !== exp_v || (exp_v && out_d[1] !== 5'(k - 3)) || in_r[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL stream k=%0d got v=%b d=%h r=%b exp v=%b d=%h r=1", k, out_v[1], out_d[1], in_r[1], exp_v, 5'(k - 3));
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic exp_v;
        out_r = 2'b10;
        for (int k = 0; k < 6; k++) begin
            in_v[0] = (k < 3);
            in_d[0] = 5'(k + 1);
            @(negedge CLK);
            n_chk++;
            if (in_r[0] !== (k < 3)) begin
                n_fail++;
                $display("FAIL bp_ready k=%0d got %b exp %b", k, in_r[0], (k < 3));
            end
            if (k >= 3) begin
                n_chk++;
                if (out_v[0] !== 1'b1 || out_d[0] !== 5'd1) begin
                    n_fail++;
                    $display("FAIL bp_hold k=%0d got v=%b d=%h exp 1/01", k, out_v[0], out_d[0]);
                end
            end
            next_cycle();
        end
        // Release with a simultaneous accept of token 4 into the full lane.
        out_r[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_v[0] = (k == 0);
            in_d[0] = 5'd4;
            @(negedge CLK);
            exp_v = (k < 4);
            n_chk++;
            if (out_v[0] !== exp_v || (exp_v && out_d[0] !== 5'(k + 1)) || in_r[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_release k=%0d got v=%b d=%h r=%b exp v=%b d=%h r=1", k, out_v[0], out_d[0], in_r[0], exp_v, 5'(k + 1));
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_independence();
        logic [4:0] sent [20];
        logic       exp_v;
        out_r = 2'b10;
        for (int k = 0; k < 30; k++) begin
            in_v[0] = 1'b1;
            in_d[0] = 5'($urandom);
            in_v[1] = (k < 20);
            in_d[1] = 5'($urandom);
            if (k < 20) sent[k] = in_d[1];
            @(negedge CLK);
            exp_v = (k >= 3) && (k < 23);
            n_chk++;
            if (out_v[1] !== exp_v || (exp_v && out_d[1] !== sent[(k >= 3 && k < 23) ? k - 3 : 0])) begin
                n_fail++;
                $display("FAIL indep_lane1 k=%0d got v=%b d=%h exp v=%b", k, out_v[1], out_d[1], exp_v);
            end
            n_chk++;
            if (in_r[0] !== (k < 3) || in_r[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL indep_ready k=%0d got %b exp %b1", k, in_r, (k < 3));
            end
            for (int l = 0; l < 2; l++) begin
                n_chk++;
                if (out_v[l] !== m_valid(l) || (m_valid(l) && out_d[l] !== m_data(l))) begin
                    n_fail++;
                    $display("FAIL indep_model lane%0d k=%0d got v=%b d=%h exp v=%b d=%h", l, k, out_v[l], out_d[l], m_valid(l), m_data(l));
                end
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_midreset();
        out_r = 2'b11;
        in_v  = 2'b01;
        in_d[0] = 5'h07;
        next_cycle();
        in_d[0] = 5'h09;
        next_cycle();
        in_v = 2'b00;
        @(negedge CLK);
        #2 rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            n_chk++;
            if (out_v !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_flush k=%0d got valid=%b exp 00", k, out_v);
            end
            next_cycle();
        end
        for (int k = 0; k < 6; k++) begin
            in_v[0] = (k == 0);
            in_d[0] = 5'h0A;
            @(negedge CLK);
            n_chk++;
            if (out_v[0] !== (k == 3) || (k == 3 && out_d[0] !== 5'h0A)) begin
                n_fail++;
                $display("FAIL midreset_next k=%0d got v=%b d=%h exp v=%b d=0a", k, out_v[0], out_d[0], (k == 3));
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_v    = 2'($urandom);
            in_d[0] = 5'($urandom);
            in_d[1] = 5'($urandom);
            out_r[0] = ($urandom_range(0, 9) < 7);
            out_r[1] = ($urandom_range(0, 9) < 4);
            @(negedge CLK);
            for (int l = 0; l < 2; l++) begin
                n_chk++;
                if (out_v[l] !== m_valid(l) || (m_valid(l) && out_d[l] !== m_data(l)) || in_r[l] !== m_ready(l)) begin
                    n_fail++;
                    $display("FAIL random lane%0d k=%0d got v=%b d=%h r=%b exp v=%b d=%h r=%b",
                             l, k, out_v[l], out_d[l], in_r[l], m_valid(l), m_data(l), m_ready(l));
                end
            end
            next_cycle();
        end
        drain();
    endtask

    initial begin
        rst_n   = 1'b0;
        in_v    = 2'b00;
        out_r   = 2'b00;
        in_d[0] = 5'd0;
        in_d[1] = 5'd0;
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_independence();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inner_inner_delay_unit.md
# inner_inner_delay_unit

Two-lane, fixed-latency, ready/valid delay pipeline for 5-bit tokens. It is the innermost leaf of the delay-unit hierarchy. Each lane carries its own stream: INPUT_i to OUTPUT_i. Wrapping levels may cross lanes, but this block never does. Each lane is a 3-stage elastic register pipeline: tokens emerge exactly 3 cycles after acceptance when unstalled, and the lane stalls without loss or duplication under backpressure.

## Interface
- DATA_WIDTH, default 5: token width per lane.
- DEPTH, default 3: register stages per lane; sets the unstalled latency.
- CLK, input, 1: sole clock, rising edge.
- ASYNCRESETN, input, 1: reset, asynchronous assert, active-low.
- INPUT_0_data, input, DATA_WIDTH: lane 0 token in.
- INPUT_0_valid, input, 1: lane 0 token present.
- INPUT_0_ready, output, 1: lane 0 can accept.
- INPUT_1_data / INPUT_1_valid / INPUT_1_ready: same as above, for lane 1.
- OUTPUT_0_data, output, DATA_WIDTH: lane 0 token out.
- OUTPUT_0_valid, output, 1: lane 0 token present.
- OUTPUT_0_ready, input, 1: lane 0 consumer accepts.
- OUTPUT_1_data / OUTPUT_1_valid / OUTPUT_1_ready: same as above, for lane 1.

## Operation
- The two lanes are fully independent. No shared state, no arbitration.
- Each lane has stages s[0..DEPTH-1], each holding a valid bit and a data register. s[0] is the input side and s[DEPTH-1] drives OUTPUT_i.
- OUTPUT_i_valid = s[DEPTH-1].valid. OUTPUT_i_data = s[DEPTH-1].data.
- Stage k may load when it is empty, or when its contents move on in the same cycle. Define adv[DEPTH-1] = !valid | OUTPUT_i_ready, and adv[k] = !s[k].valid | adv[k+1]. Bubbles collapse.
- INPUT_i_ready = adv[0], gated low while ASYNCRESETN is low. The path from OUTPUT_i_ready to INPUT_i_ready is combinational.
- Transfer occurs only on valid & ready on a rising CLK edge.
- A stage with adv[k]=1 loads s[k-1], or the input for k=0. Its valid bit takes the upstream valid/transfer.
- A stage with adv[k]=0 holds its contents.
- Data registers load only when the incoming valid is 1, so stage data is don't-care when invalid.
- Tokens are never dropped, duplicated, or reordered.
- Data passes unmodified, with no width change.

## Timing
- Reset (ASYNCRESETN=0): all valid bits clear to 0 and all data registers clear to 0 immediately.
  - OUTPUT_*_valid=0, OUTPUT_*_data=0, INPUT_*_ready=0.
- Reset release: INPUT_*_ready=1 in the first cycle after release, because the pipeline is empty.
- Latency: a token transferred at edge t is presented on OUTPUT_i from edge t+DEPTH-1 onward. This is 3 cycles from the input-valid cycle to the output-valid cycle when unstalled.
- Throughput: 1 token per cycle per lane when OUTPUT_i_ready=1 continuously.
- Full lane (DEPTH valid stages) with OUTPUT_i_ready=0: INPUT_i_ready=0 and all contents hold.
- Full lane with OUTPUT_i_ready=1: INPUT_i_ready=1. Simultaneous consume and accept is legal, and occupancy is unchanged.
- Reset asserted mid-stream: all in-flight tokens are discarded. No output is produced for them after release.

## Structure
- Shared package delay_pkg holds:
  - DATA_WIDTH=5, DEPTH=3, NUM_LANES=2;
  - a `token_t` typedef (logic [DATA_WIDTH-1:0]);
  - a stage struct {valid, token_t data}.
- One sub-module, delay_lane: a single DEPTH-stage elastic lane. The top instantiates it twice and maps ports by name.

## Test plan
- Reset check: hold ASYNCRESETN=0 mid-cycle with inputs valid -> all outputs 0 immediately. After release, INPUT_*_ready=1 and OUTPUT_*_valid=0.
- Latency check: drive a single token 5'h15 on lane 0, then valid low, with OUTPUT_0_ready=1.
  - OUTPUT_0_valid=1 with data 5'h15 exactly 3 cycles after the input-valid cycle, for one cycle.
  - Lane 1 stays idle.
- Streaming check: feed 0..31 back-to-back on lane 1 with OUTPUT_1_ready=1 -> identical sequence out, one per cycle, starting cycle 3.
- Backpressure check: fill lane 0 with 1, 2, 3 while OUTPUT_0_ready=0.
  - INPUT_0_ready drops to 0 after the 3rd accept.
  - Raising OUTPUT_0_ready yields 1, 2, 3 in order with no loss.
- Lane independence: stall lane 0 while streaming lane 1 -> lane 1 is unaffected, 1 token/cycle.
- Mid-stream reset: reset pulse with 2 tokens in flight -> no output after release; the next token arrives with 3-cycle latency.
